// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, redirect request and the decode handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface inst_fetch_unit_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      mem_address;
  logic [31:0]      mem_instruction;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instruction;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output mem_address,
    input  mem_instruction,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instruction,
    output fifo_count
  );

  modport slave (
    input  mem_address,
    output mem_instruction,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instruction,
    input  fifo_count
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: walks the fetch PC, captures memory words into a small
// prefetch FIFO and hands {pc, instruction} to decode; redirects flush and restart fetch.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [31:0]      pc_mem_q  [DEPTH];
  logic [31:0]      pc_mem_d  [DEPTH];
  logic [31:0]      ins_mem_q [DEPTH];
  logic [31:0]      ins_mem_d [DEPTH];

  logic head_valid;
  logic pop;
  logic push;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.out_ready;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign push       = ~bus.redirect_valid & ((count_q < DEPTH_C) | pop);

  assign bus.mem_address     = fetch_pc_q;
  assign bus.out_valid       = head_valid;
  assign bus.out_pc          = pc_mem_q[rd_ptr_q];
  assign bus.out_instruction = ins_mem_q[rd_ptr_q];
  assign bus.fifo_count      = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    if (bus.redirect_valid) begin
      // Redirect discards everything in flight, including a coincident pop/push.
      fetch_pc_d = bus.redirect_pc & PC_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]  = fetch_pc_q;
        ins_mem_d[wr_ptr_q] = bus.mem_instruction;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        fetch_pc_d          = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC & PC_MASK;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C);
  a_addr_align:  assert property (@(posedge clk) disable iff (!rst) fetch_pc_q[1:0] == 2'b00);

endmodule
